fpu_wb_buf: RTL and testbench
=============================

FPU_WB_BUF -- requirements
Module: fpu_wb_buf

Interface
REQ-001 Parameter DEPTH, default 4, number of result entries; SHALL be a power of two, 2..16.
REQ-002 Parameter TAGW, default 5, destination-register tag width.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discard all buffered entries.
REQ-006 in_valid  input  1  converter result present.
REQ-007 in_ready  output  1  buffer can accept this cycle.
REQ-008 in_data  input  32  IEEE-754 single result from the int-to-float converter.
REQ-009 in_tag  input  TAGW  destination FP register.
REQ-010 out_valid  output  1  head entry present to writeback.
REQ-011 out_ready  input  1  writeback port accepts.
REQ-012 out_data  output  32  head result.
REQ-013 out_tag  output  TAGW  head tag.
REQ-014 out_zero  output  1  head result exponent field == 0.
REQ-015 count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-016 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-017 Buffer SHALL be FIFO-ordered; results leave in acceptance order, data and tag unmodified.
REQ-018 in_ready SHALL be 1 iff count < DEPTH, or count == DEPTH and out_ready is 1 (pop frees a slot the same cycle).
REQ-019 out_valid SHALL be 1 iff count > 0 (with bypass: see REQ-029).
REQ-020 out_zero SHALL be computed at push time from in_data[30:23] == 0 and stored per entry.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, advance both pointers.
REQ-022 Read/write pointers SHALL wrap from DEPTH-1 to 0.
REQ-023 Minimum push-to-out_valid latency SHALL be 1 cycle without bypass.
REQ-024 flush SHALL, at the next edge, empty the buffer (count 0, pointers 0) and ignore any same-cycle push; flush has priority over push and pop.
REQ-025 out_data/out_tag SHALL hold stable while out_valid && !out_ready.
REQ-026 in_data/in_tag values when no push occurs SHALL not affect state.

Reset
REQ-027 On rst: count 0, pointers 0, out_valid 0, in_ready 1; out_data, out_tag, out_zero 0; stored entry contents need not be cleared.
REQ-028 rst SHALL take priority over flush, push and pop; a transfer in the reset cycle is lost.

Configuration
REQ-029 Macro FPU_WB_BYPASS_EN defined: when count == 0 and in_valid, out_valid SHALL be 1 combinationally with out_data/out_tag/out_zero taken from the input; if out_ready is also 1, the result is consumed without being stored (count stays 0); otherwise it is pushed.
REQ-030 Macro undefined: no combinational in-to-out path; every result is stored first (REQ-023).

Structure
REQ-031 Shared FPU package SHALL hold the float field constants (sign bit 31, exponent 30:23, mantissa 22:0) and the default tag width.
REQ-032 Storage SHALL be one sub-module fpu_wb_ram (DEPTH x (32+TAGW+1), one write port, one async read port); pointer/count control stays in fpu_wb_buf.

Verification
REQ-033 Push 0x4B000000 tag 3 into empty buffer, out_ready 1 -> out_valid next cycle (same cycle with bypass), out_data 0x4B000000, out_tag 3, out_zero 0.
REQ-034 out_ready 0, push 4 results -> count 4, in_ready 0; 5th offered result not accepted; then out_ready 1 -> four results drain in order.
REQ-035 Full buffer, in_valid 1 and out_ready 1 same cycle -> in_ready 1, count stays 4, head advances.
REQ-036 Push 0x00000000 tag 7 -> out_zero 1; push 0xCF000000 -> out_zero 0.
REQ-037 count 3 with push pending, assert flush -> next cycle count 0, out_valid 0, pushed value never appears.
REQ-038 Assert rst while count 2 -> next cycle count 0, out_valid 0, in_ready 1, outputs 0.

Source files
------------

// File: rtl/fpu_wb_buf_pkg.sv
// Shared FPU constants: IEEE-754 single field positions and default tag width.
// Helper: exp_is_zero() flags a result whose exponent field is all zeros.
package fpu_wb_buf_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;
  localparam int MAN_LSB  = 0;
  localparam int FPU_TAGW = 5;

  function automatic logic exp_is_zero(
    input logic [31:0] d
  );
    return d[EXP_MSB:EXP_LSB] == '0;
  endfunction

endpackage

// File: rtl/fpu_wb_buf_if.sv
// Converter-to-writeback handshake bundle: in_* push side, out_* pop side.
// slave = buffer view, master = producer/consumer (bench) view.
interface fpu_wb_buf_if #(
  parameter int TAGW = fpu_wb_buf_pkg::FPU_TAGW
) ();

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_data;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_data;
  logic [TAGW-1:0] out_tag;
  logic            out_zero;

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero
  );

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero
  );

endinterface

// File: rtl/fpu_wb_ram.sv
// Result storage: DEPTH x W, one synchronous write port, one async read port.
// Ports: clk, we/waddr/wdata write side, raddr/rdata read side.
module fpu_wb_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 38,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fpu_wb_buf.sv
// FIFO between int-to-float converter and FP writeback (clk, rst, flush, bus, count).
// Optional macro FPU_WB_BYPASS_EN: empty-buffer results pass straight to the output.
module fpu_wb_buf
  import fpu_wb_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = FPU_TAGW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  fpu_wb_buf_if.slave            bus,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 32 + TAGW + 1;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic [EW-1:0] wentry;
  logic [EW-1:0] rentry;
  logic          stored;
  logic          full;
  logic          push;
  logic          pop;

  // entry layout: {zero, tag, data}
  assign wentry = {exp_is_zero(bus.in_data), bus.in_tag, bus.in_data};

  assign stored       = cnt != '0;
  assign full         = cnt == CW'(DEPTH);
  assign bus.in_ready = !full || bus.out_ready;
  assign pop          = stored && bus.out_ready;
  assign count        = cnt;

`ifdef FPU_WB_BYPASS_EN
  logic byp;
  assign byp  = !stored && bus.in_valid;
  // a bypassed result taken this cycle is never stored
  assign push = bus.in_valid && bus.in_ready
             && !(byp && bus.out_ready);
  assign bus.out_valid = stored || byp;
  assign bus.out_data  = stored ? rentry[31:0]
                       : byp ? bus.in_data : '0;
  assign bus.out_tag   = stored ? rentry[32 +: TAGW]
                       : byp ? bus.in_tag : '0;
  assign bus.out_zero  = stored ? rentry[EW-1]
                       : byp && wentry[EW-1];
`else
  assign push          = bus.in_valid && bus.in_ready;
  assign bus.out_valid = stored;
  // outputs read as zero while empty so stale slots never leak
  assign bus.out_data  = stored ? rentry[31:0] : '0;
  assign bus.out_tag   = stored ? rentry[32 +: TAGW] : '0;
  assign bus.out_zero  = stored && rentry[EW-1];
`endif

  fpu_wb_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata (wentry),
    .raddr (rptr),
    .rdata (rentry)
  );

  // power-of-two DEPTH: pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fpu_wb_buf.sv
// Bench for fpu_wb_buf: queue model checked every cycle plus directed literals.
// Drives through the interface master side; default (no bypass) build.
module tb_fpu_wb_buf;

  localparam int DEPTH = 4;
  localparam int TAGW  = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] count;

  fpu_wb_buf_if #(.TAGW(TAGW)) bus ();

  fpu_wb_buf #(
    .DEPTH (DEPTH),
    .TAGW  (TAGW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave),
    .count (count)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [31:0]     d;
    logic [TAGW-1:0] t;
    logic            z;
  } ent_t;

  ent_t q[$];
  ent_t e;
  bit   m_push;
  bit   m_pop;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // model: a queue updated with the handshake rules
  always @(posedge clk) begin
    if (rst || flush) begin
      q.delete();
    end else begin
      m_pop  = q.size() > 0 && bus.out_ready;
      m_push = bus.in_valid
            && (q.size() < DEPTH || bus.out_ready);
      e.d = bus.in_data;
      e.t = bus.in_tag;
      e.z = (bus.in_data & 32'h7F80_0000) == 32'h0;
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_count", 32'(count), 32'(q.size()));
      check("m_out_valid", 32'(bus.out_valid),
            32'(q.size() > 0));
      check("m_in_ready", 32'(bus.in_ready),
            32'(q.size() < DEPTH || bus.out_ready));
      if (q.size() > 0) begin
        check("m_out_data", bus.out_data, q[0].d);
        check("m_out_tag", 32'(bus.out_tag), 32'(q[0].t));
        check("m_out_zero", 32'(bus.out_zero), 32'(q[0].z));
      end
    end
  end

  task automatic drive(input bit v,
                       input logic [31:0] d,
                       input logic [TAGW-1:0] t,
                       input bit ordy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_tag    = t;
    bus.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_ready"}, 32'(bus.in_ready), 1);
    check({tag, "_data"}, bus.out_data, 0);
    check({tag, "_tag"}, 32'(bus.out_tag), 0);
    check({tag, "_zero"}, 32'(bus.out_zero), 0);
  endtask

  logic [31:0] rd;

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    drive(0, 32'h0, '0, 0);
    tick();
    tick();
    rst    = 1'b0;
    chk_en = 1'b1;
    #1;
    check_reset_outs("rst0");

    // single result, one-cycle latency
    drive(1, 32'h4B00_0000, 5'd3, 1);
    #1;
    check("lat_pre_valid", 32'(bus.out_valid), 0);
    tick();
    drive(0, 32'hFFFF_FFFF, 5'h1F, 1);
    #1;
    check("lat_valid", 32'(bus.out_valid), 1);
    check("lat_data", bus.out_data, 32'h4B00_0000);
    check("lat_tag", 32'(bus.out_tag), 3);
    check("lat_zero", 32'(bus.out_zero), 0);
    tick();
    check("lat_drained", 32'(count), 0);

    // fill, refuse fifth, drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h3F80_0000 + i, 5'(i + 1), 0);
      tick();
    end
    check("full_count", 32'(count), 4);
    check("full_ready", 32'(bus.in_ready), 0);
    drive(1, 32'h1234_5678, 5'd9, 0);
    #1;
    check("fifth_ready", 32'(bus.in_ready), 0);
    tick();
    check("fifth_count", 32'(count), 4);
    drive(0, 32'h0, '0, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_data", bus.out_data, 32'h3F80_0000 + i);
      check("drain_tag", 32'(bus.out_tag), i + 1);
      tick();
    end
    check("drain_count", 32'(count), 0);

    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h4000_0000 + i, 5'(10 + i), 0);
      tick();
    end
    drive(1, 32'h4100_0000, 5'd20, 1);
    #1;
    check("pp_ready", 32'(bus.in_ready), 1);
    tick();
    drive(0, 32'h0, '0, 0);
    #1;
    check("pp_count", 32'(count), 4);
    check("pp_head", bus.out_data, 32'h4000_0001);
    drive(0, 32'h0, '0, 1);
    repeat (4) tick();
    check("pp_empty", 32'(count), 0);

    // zero-exponent flag
    drive(1, 32'h0000_0000, 5'd7, 0);
    tick();
    drive(1, 32'hCF00_0000, 5'd8, 0);
    tick();
    drive(0, 32'h0, '0, 0);
    #1;
    check("z_head_zero", 32'(bus.out_zero), 1);
    check("z_head_tag", 32'(bus.out_tag), 7);
    drive(0, 32'h0, '0, 1);
    tick();
    check("z_next_zero", 32'(bus.out_zero), 0);
    check("z_next_data", bus.out_data, 32'hCF00_0000);
    tick();

    // flush with a push pending
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h5000_0000 + i, 5'(i), 0);
      tick();
    end
    check("fl_pre_count", 32'(count), 3);
    drive(1, 32'hDEAD_BEEF, 5'd21, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(0, 32'h0, '0, 1);
    #1;
    check("fl_count", 32'(count), 0);
    check("fl_valid", 32'(bus.out_valid), 0);
    repeat (3) tick();
    check("fl_still_empty", 32'(bus.out_valid), 0);

    // reset while holding two entries
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h6000_0000 + i, 5'(i), 0);
      tick();
    end
    check("rs_pre_count", 32'(count), 2);
    rst = 1'b1;
    drive(1, 32'h1111_1111, 5'd5, 1);
    tick();
    rst = 1'b0;
    drive(0, 32'h0, '0, 0);
    #1;
    check_reset_outs("rst1");

    // mixed traffic for wrap-around, model checks each cycle
    for (int i = 0; i < 300; i++) begin
      rd = $urandom;
      if ($urandom_range(0, 3) == 0) rd &= 32'h807F_FFFF;
      drive(1'($urandom_range(0, 1)), rd,
            5'($urandom_range(0, 31)),
            1'($urandom_range(0, 2) != 0));
      flush = ($urandom_range(0, 49) == 0);
      tick();
    end
    flush = 1'b0;
    drive(0, 32'h0, '0, 1);
    repeat (6) tick();
    check("end_empty", 32'(count), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
